// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes, encoder kind codes and word-format helpers.
// Pure declarations: no latency, no backpressure.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_JR     = 6'b001000;
    localparam logic [5:0] F_ADD    = 6'b100000;

    localparam logic [4:0] SP_REG   = 5'd29;

    typedef enum logic [3:0] {
        K_RTYPE = 4'd0,
        K_LW    = 4'd1,
        K_SW    = 4'd2,
        K_BEQ   = 4'd3,
        K_J     = 4'd4,
        K_JAL   = 4'd5,
        K_ADDI  = 4'd6,
        K_JR    = 4'd7,
        K_NOP   = 4'd8,
        K_PUSH  = 4'd9,
        K_POP   = 4'd10
    } kind_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } enc_state_e;

    function automatic logic [31:0] fmt_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] fmt_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] fmt_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_word_fmt.sv
// Maps a decoded descriptor to its machine word(s); PUSH/POP expand to two words.
// Combinational, zero latency, no backpressure.
module instr_word_fmt
    import mips_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word0,
    output logic [31:0] o_word1,
    output logic        o_two_words,
    output logic        o_illegal
);

    always_comb begin
        o_word0     = 32'h0;
        o_word1     = 32'h0;
        o_two_words = 1'b0;
        o_illegal   = 1'b0;
        case (i_kind)
            K_RTYPE: o_word0 = fmt_r(i_rs, i_rt, i_rd, i_funct);
            K_LW:    o_word0 = fmt_i(OP_LW,   i_rs, i_rt, i_imm);
            K_SW:    o_word0 = fmt_i(OP_SW,   i_rs, i_rt, i_imm);
            K_BEQ:   o_word0 = fmt_i(OP_BEQ,  i_rs, i_rt, i_imm);
            K_J:     o_word0 = fmt_j(OP_J,    i_target);
            K_JAL:   o_word0 = fmt_j(OP_JAL,  i_target);
            K_ADDI:  o_word0 = fmt_i(OP_ADDI, i_rs, i_rt, i_imm);
            K_JR:    o_word0 = fmt_r(i_rs, 5'd0, 5'd0, F_JR);
            K_NOP:   o_word0 = 32'h0;
            // Stack grows down by one word; the store/load uses offset 0 from the adjusted SP.
            K_PUSH: begin
                o_word0     = fmt_i(OP_ADDI, SP_REG, SP_REG, 16'hFFFC);
                o_word1     = fmt_i(OP_SW,   SP_REG, i_rt,   16'h0000);
                o_two_words = 1'b1;
            end
            K_POP: begin
                o_word0     = fmt_i(OP_LW,   SP_REG, i_rt,   16'h0000);
                o_word1     = fmt_i(OP_ADDI, SP_REG, SP_REG, 16'h0004);
                o_two_words = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder: packs descriptors into words written to consecutive imem addresses.
// Word0 registered one edge after accept, word1 (PUSH/POP) the edge after; in_ready low in SECOND, when full, in clear/reset.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] L_LAST  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] L_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        r_state;
    enc_state_e        w_nxt_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       r_word1;

    logic              w_nxt_we;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [31:0]       w_nxt_wdata;
    logic [ADDR_W:0]   w_nxt_count;
    logic              w_nxt_err;
    logic [31:0]       w_nxt_word1;

    logic [31:0]       w_word0;
    logic [31:0]       w_word1;
    logic              w_two_words;
    logic              w_illegal;
    logic              w_full;
    logic              w_acc;

    instr_word_fmt u_fmt (
        .i_kind      (in_kind),
        .i_rs        (in_rs),
        .i_rt        (in_rt),
        .i_rd        (in_rd),
        .i_funct     (in_funct),
        .i_imm       (in_imm),
        .i_target    (in_target),
        .o_word0     (w_word0),
        .o_word1     (w_word1),
        .o_two_words (w_two_words),
        .o_illegal   (w_illegal)
    );

    assign w_full   = (r_count == L_DEPTH);
    assign in_ready = (r_state == ST_IDLE) && !w_full && !clear && rst_n;
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_we    = 1'b0;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_nxt_count = r_count;
        w_nxt_err   = r_err;
        w_nxt_word1 = r_word1;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    // A two-word op must fit entirely or not be written at all.
                    if (w_illegal || (w_two_words && r_count == L_LAST)) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_we    = 1'b1;
                        w_nxt_addr  = r_count[ADDR_W-1:0];
                        w_nxt_wdata = w_word0;
                        w_nxt_count = r_count + L_ONE;
                        if (w_two_words) begin
                            w_nxt_state = ST_SECOND;
                            w_nxt_word1 = w_word1;
                        end
                    end
                end
            end
            ST_SECOND: begin
                w_nxt_we    = 1'b1;
                w_nxt_addr  = r_count[ADDR_W-1:0];
                w_nxt_wdata = r_word1;
                w_nxt_count = r_count + L_ONE;
                w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_word1 <= 32'h0;
        end else if (clear) begin
            r_we    <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we    <= w_nxt_we;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_count <= w_nxt_count;
            r_err   <= w_nxt_err;
            r_word1 <= w_nxt_word1;
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = w_full;
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a deep instance (ADDR_W=8) and a tiny one (ADDR_W=2).
module tb_instr_encoder;
    import mips_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clear1, clear2;
    logic        vld1, vld2;
    logic        rdy1, rdy2;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;

    logic        we1, we2;
    logic [7:0]  addr1;
    logic [1:0]  addr2;
    logic [31:0] wdata1, wdata2;
    logic [8:0]  cnt1;
    logic [2:0]  cnt2;
    logic        full1, full2, err1, err2;

    exp_t q1[$];
    exp_t q2[$];
    int   wc1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    instr_encoder #(.ADDR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(vld1), .in_ready(rdy1),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(fn),
        .in_imm(imm), .in_target(tg), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wdata1), .count(cnt1), .full(full1), .err(err1)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(vld2), .in_ready(rdy2),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(fn),
        .in_imm(imm), .in_target(tg), .imem_we(we2), .imem_addr(addr2),
        .imem_wdata(wdata2), .count(cnt2), .full(full2), .err(err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (we1) begin
            wc1.push_back(cyc);
            if (q1.size() == 0) begin
                chk("unexpected_wr1", {63'd0, we1}, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", {56'd0, addr1}, {56'd0, e.addr});
                chk("wr1_data", {32'd0, wdata1}, {32'd0, e.data});
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (we2) begin
            if (q2.size() == 0) begin
                chk("unexpected_wr2", {63'd0, we2}, 64'd0);
            end else begin
                e = q2.pop_front();
                chk("wr2_addr", {62'd0, addr2}, {56'd0, e.addr});
                chk("wr2_data", {32'd0, wdata2}, {32'd0, e.data});
            end
        end
    end

    task automatic expect1(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        q1.push_back(e);
    endtask

    task automatic expect2(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        q2.push_back(e);
    endtask

    // Present one descriptor to the selected instance; acc = cycle index of the accepting edge.
    task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [5:0] a_fn,
                        input logic [15:0] a_imm, input logic [25:0] a_tg, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        kind = k; rs = a_rs; rt = a_rt; rd = a_rd; fn = a_fn; imm = a_imm; tg = a_tg;
        if (sel) vld2 = 1'b1;
        else     vld1 = 1'b1;
        while (!(sel ? rdy2 : rdy1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk("ready_timeout", n, 0);
            vld1 = 1'b0;
            vld2 = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            vld1 = 1'b0;
            vld2 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int a0, a1;
        rst_n = 1'b0; clear1 = 1'b0; clear2 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; fn = '0; imm = '0; tg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",    {63'd0, we1},     64'd0);
        chk("rst_addr",  {56'd0, addr1},   64'd0);
        chk("rst_wdata", {32'd0, wdata1},  64'd0);
        chk("rst_count", {55'd0, cnt1},    64'd0);
        chk("rst_full",  {63'd0, full1},   64'd0);
        chk("rst_err",   {63'd0, err1},    64'd0);
        chk("rst_ready", {63'd0, rdy1},    64'd0);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_rst", {63'd0, rdy1}, 64'd1);

        // ADDI then RTYPE back to back
        wc1.delete();
        expect1(8'd0, 32'h20080005);
        send(1'b0, K_ADDI, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, a0);
        expect1(8'd1, 32'h01095020);
        send(1'b0, K_RTYPE, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, a1);
        idle(2);
        chk("b2b_accept", a1, a0 + 1);
        chk("lat_word0", wc1.size() > 0 ? wc1[0] : -1, a0);
        chk("lat_word1", wc1.size() > 1 ? wc1[1] : -1, a0 + 1);
        chk("count_2", {55'd0, cnt1}, 64'd2);

        // PUSH: ready drops for exactly one cycle
        wc1.delete();
        expect1(8'd2, 32'h23BDFFFC);
        expect1(8'd3, 32'hAFA80000);
        send(1'b0, K_PUSH, 5'd3, 5'd8, 5'd7, 6'h3F, 16'h1234, 26'd0, a0);
        chk("push_ready_low", {63'd0, rdy1}, 64'd0);
        idle(1);
        chk("push_ready_high", {63'd0, rdy1}, 64'd1);
        idle(1);
        chk("push_w1_lat", wc1.size() > 1 ? wc1[1] : -1, a0 + 1);

        // POP then J
        expect1(8'd4, 32'h8FA80000);
        expect1(8'd5, 32'h23BD0004);
        expect1(8'd6, 32'h08000010);
        send(1'b0, K_POP, 5'd0, 5'd8, 5'd0, 6'd0, 16'd0, 26'd0, a0);
        send(1'b0, K_J, 5'd1, 5'd2, 5'd3, 6'd0, 16'hFFFF, 26'h0000010, a1);
        idle(2);
        chk("j_accept_after_second", a1, a0 + 2);
        chk("count_7", {55'd0, cnt1}, 64'd7);

        // Illegal kind consumed with no write, then JR still encodes
        send(1'b0, 4'd13, 5'd1, 5'd2, 5'd3, 6'd4, 16'd5, 26'd6, a0);
        idle(2);
        chk("illegal_err", {63'd0, err1}, 64'd1);
        chk("illegal_count", {55'd0, cnt1}, 64'd7);
        expect1(8'd7, 32'h03E00008);
        send(1'b0, K_JR, 5'd31, 5'd4, 5'd5, 6'h20, 16'hABCD, 26'd0, a0);
        idle(2);
        chk("jr_count", {55'd0, cnt1}, 64'd8);
        chk("q1_drained", q1.size(), 0);

        // Small instance: fill, non-fitting PUSH, full, clear beating a valid descriptor
        for (int i = 0; i < 3; i++) begin
            expect2(i[7:0], 32'h0);
            send(1'b1, K_NOP, 5'd9, 5'd9, 5'd9, 6'd9, 16'd9, 26'd9, a0);
        end
        send(1'b1, K_PUSH, 5'd0, 5'd8, 5'd0, 6'd0, 16'd0, 26'd0, a0);
        idle(2);
        chk("nofit_err", {63'd0, err2}, 64'd1);
        chk("nofit_count", {61'd0, cnt2}, 64'd3);
        expect2(8'd3, 32'h0);
        send(1'b1, K_NOP, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, a0);
        idle(1);
        chk("full_count", {61'd0, cnt2}, 64'd4);
        chk("full_flag", {63'd0, full2}, 64'd1);
        chk("full_ready", {63'd0, rdy2}, 64'd0);
        @(negedge clk);
        clear2 = 1'b1;
        vld2 = 1'b1;
        kind = K_NOP;
        @(posedge clk);
        #1;
        clear2 = 1'b0;
        vld2 = 1'b0;
        chk("clear_count", {61'd0, cnt2}, 64'd0);
        chk("clear_err", {63'd0, err2}, 64'd0);
        chk("clear_full", {63'd0, full2}, 64'd0);
        idle(2);
        chk("clear_wins", {61'd0, cnt2}, 64'd0);
        chk("q2_drained", q2.size(), 0);

        // Reset while in SECOND drops word1
        expect1(8'd8, 32'h23BDFFFC);
        send(1'b0, K_PUSH, 5'd0, 5'd5, 5'd0, 6'd0, 16'd0, 26'd0, a0);
        rst_n = 1'b0;
        idle(1);
        chk("rs2_we",    {63'd0, we1},    64'd0);
        chk("rs2_addr",  {56'd0, addr1},  64'd0);
        chk("rs2_wdata", {32'd0, wdata1}, 64'd0);
        chk("rs2_count", {55'd0, cnt1},   64'd0);
        chk("rs2_err",   {63'd0, err1},   64'd0);
        chk("rs2_full",  {63'd0, full1},  64'd0);
        chk("rs2_ready", {63'd0, rdy1},   64'd0);
        rst_n = 1'b1;
        idle(3);
        chk("rs2_no_word1", {55'd0, cnt1}, 64'd0);
        chk("q1_final", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
